// File: rtl/ymc_control.sv
// ymc_control: multicycle control sequencer for the RV32I-subset datapath.
// Holds the current instruction in an internal register and walks it
// through FETCH -> DECODE -> EXEC -> MEM -> WB. It drives the execute,
// data-memory and write-back control inputs each cycle, and it counts
// retired instructions.
//
// Ports:
//   clk       sole clock, rising edge
//   reset     synchronous active-high reset
//   memOut    instruction word from memory (captured in FETCH on memReady)
//   memReady  memory completes the current access this cycle
//   zero      ALU zero flag (branch resolution in EXEC)
//   ins       instruction register
//   op        ALU op: 000 and, 001 or, 010 add, 110 sub, 111 slt
//   ALUSrc    0 = rd2, 1 = immediate
//   MemRead   memory read request (instruction in FETCH, data in MEM)
//   MemWrite  data memory write request
//   Mem2Reg   write-back selects memory data
//   wbPC      write-back selects PC+4 (JAL link)
//   RegWrite  register file write enable
//   pcWrite   PC load strobe, one pulse per retired instruction
//   pcSel     next PC: 00 PC+4, 01 branch target, 10 jump target
//   illegal   sticky unsupported-instruction flag
//   instret   retired instruction count (wraps)
module ymc_control #(
    parameter int IW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [IW-1:0] memOut,
    input  logic          memReady,
    input  logic          zero,
    output logic [IW-1:0] ins,
    output logic [2:0]    op,
    output logic          ALUSrc,
    output logic          MemRead,
    output logic          MemWrite,
    output logic          Mem2Reg,
    output logic          wbPC,
    output logic          RegWrite,
    output logic          pcWrite,
    output logic [1:0]    pcSel,
    output logic          illegal,
    output logic [IW-1:0] instret
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    state_t        state_reg, state_next;
    logic [IW-1:0] ins_reg;
    logic [IW-1:0] instret_reg;
    logic          illegal_reg;

    // Instruction classification, taken from the instruction register.
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       is_r, is_i, is_lw, is_sw, is_beq, is_jal;
    logic       alu_f3_ok;
    logic [2:0] alu_op;
    logic       legal;

    assign opcode = ins_reg[6:0];
    assign funct3 = ins_reg[14:12];
    assign is_r   = (opcode == 7'b0110011);
    assign is_i   = (opcode == 7'b0010011);
    assign is_lw  = (opcode == 7'b0000011);
    assign is_sw  = (opcode == 7'b0100011);
    assign is_beq = (opcode == 7'b1100011);
    assign is_jal = (opcode == 7'b1101111);

    always_comb begin
        alu_op    = 3'b000;
        alu_f3_ok = 1'b1;
        case (funct3)
            3'b000:  alu_op = (is_r && ins_reg[30]) ? 3'b110 : 3'b010;
            3'b111:  alu_op = 3'b000;
            3'b110:  alu_op = 3'b001;
            3'b010:  alu_op = 3'b111;
            default: alu_f3_ok = 1'b0;
        endcase
    end

    assign legal = ((is_r || is_i) && alu_f3_ok) || is_lw || is_sw ||
                   (is_beq && funct3 == 3'b000) || is_jal;

    // retire is the ungated pcWrite: the counter and the PC move together.
    logic retire;
    logic set_illegal;

    always_comb begin
        state_next  = state_reg;
        op          = 3'b000;
        ALUSrc      = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        Mem2Reg     = 1'b0;
        wbPC        = 1'b0;
        RegWrite    = 1'b0;
        pcWrite     = 1'b0;
        pcSel       = 2'b00;
        set_illegal = 1'b0;
        case (state_reg)
            S_FETCH: begin
                MemRead = 1'b1;
                if (memReady) state_next = S_DECODE;
            end
            S_DECODE: begin
                if (!legal) begin
                    set_illegal = 1'b1;
                    state_next  = S_HALT;
                end else if (is_jal) begin
                    state_next = S_WB;
                end else begin
                    state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                if (is_r || is_i) begin
                    ALUSrc     = is_i;
                    op         = alu_op;
                    state_next = S_WB;
                end else if (is_lw || is_sw) begin
                    ALUSrc     = 1'b1;
                    op         = 3'b010;
                    state_next = S_MEM;
                end else begin
                    // BEQ resolves here: subtract and steer the PC on zero.
                    op         = 3'b110;
                    pcWrite    = 1'b1;
                    pcSel      = zero ? 2'b01 : 2'b00;
                    state_next = S_FETCH;
                end
            end
            S_MEM: begin
                ALUSrc   = 1'b1;
                op       = 3'b010;
                MemRead  = is_lw;
                MemWrite = is_sw;
                if (memReady) begin
                    if (is_sw) begin
                        pcWrite    = 1'b1;
                        state_next = S_FETCH;
                    end else begin
                        state_next = S_WB;
                    end
                end
            end
            S_WB: begin
                RegWrite   = 1'b1;
                pcWrite    = 1'b1;
                Mem2Reg    = is_lw;
                wbPC       = is_jal;
                pcSel      = is_jal ? 2'b10 : 2'b00;
                if (is_r || is_i) begin
                    ALUSrc = is_i;
                    op     = alu_op;
                end
                state_next = S_FETCH;
            end
            default: state_next = S_HALT;
        endcase

        retire = pcWrite;

        // Reset silences every strobe in the same cycle it is asserted.
        if (reset) begin
            op       = 3'b000;
            ALUSrc   = 1'b0;
            MemRead  = 1'b0;
            MemWrite = 1'b0;
            Mem2Reg  = 1'b0;
            wbPC     = 1'b0;
            RegWrite = 1'b0;
            pcWrite  = 1'b0;
            pcSel    = 2'b00;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= S_FETCH;
            ins_reg     <= '0;
            instret_reg <= '0;
            illegal_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (state_reg == S_FETCH && memReady) ins_reg <= memOut;
            if (retire) instret_reg <= instret_reg + IW'(1);
            if (set_illegal) illegal_reg <= 1'b1;
        end
    end

    assign ins     = ins_reg;
    assign instret = instret_reg;
    assign illegal = illegal_reg;

endmodule

// File: tb/tb_ymc_control.sv
// Directed testbench for ymc_control. Inputs are driven on the falling edge;
// outputs are sampled 1 time unit later. Strobes are compared as one packed
// vector {MemRead,MemWrite,Mem2Reg,wbPC,RegWrite,pcWrite,pcSel,ALUSrc,op}.
module tb_ymc_control;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] memOut;
    logic        memReady;
    logic        zero;
    logic [31:0] ins;
    logic [2:0]  op;
    logic        ALUSrc, MemRead, MemWrite, Mem2Reg, wbPC, RegWrite, pcWrite;
    logic [1:0]  pcSel;
    logic        illegal;
    logic [31:0] instret;
    logic [11:0] sig;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    ymc_control #(.IW(32)) dut (
        .clk(clk), .reset(reset), .memOut(memOut), .memReady(memReady),
        .zero(zero), .ins(ins), .op(op), .ALUSrc(ALUSrc), .MemRead(MemRead),
        .MemWrite(MemWrite), .Mem2Reg(Mem2Reg), .wbPC(wbPC),
        .RegWrite(RegWrite), .pcWrite(pcWrite), .pcSel(pcSel),
        .illegal(illegal), .instret(instret)
    );

    assign sig = {MemRead, MemWrite, Mem2Reg, wbPC, RegWrite, pcWrite, pcSel, ALUSrc, op};

    function automatic logic [11:0] mk(input logic mr, input logic mw, input logic m2r,
                                       input logic wbpc, input logic rw, input logic pcw,
                                       input logic [1:0] ps, input logic as, input logic [2:0] o);
        return {mr, mw, m2r, wbpc, rw, pcw, ps, as, o};
    endfunction

    localparam logic [11:0] V_F = 12'b1000_0000_0000;
    localparam logic [11:0] V_0 = 12'b0000_0000_0000;

    task automatic test_reset();
        memReady = 1'b1;
        memOut   = 32'h002081B3;
        @(negedge clk); #1;
        total_cnt++;
        if (sig !== V_0) $display("FAIL reset_strobes: got %03h expected %03h", sig, V_0);
        else pass_cnt++;
        @(negedge clk); #1;
        total_cnt++;
        if ({ins, instret, illegal} !== 65'd0)
            $display("FAIL reset_regs: ins=%08h instret=%08h illegal=%b expected all 0", ins, instret, illegal);
        else pass_cnt++;
        reset = 1'b0;
    endtask

    task automatic test_rtype();
        logic [11:0] ev [4];
        ev = '{V_F, V_0, mk(0,0,0,0,0,0,2'b00,0,3'b010), mk(0,0,0,0,1,1,2'b00,0,3'b010)};
        memOut = 32'h002081B3;
        for (int i = 0; i < 4; i++) begin
            memReady = 1'b1;
            #1;
            total_cnt++;
            if (sig !== ev[i]) $display("FAIL rtype_add cyc%0d: got %03h expected %03h", i, sig, ev[i]);
            else pass_cnt++;
            @(negedge clk);
        end
        #1;
        total_cnt++;
        if (instret !== 32'd1 || ins !== 32'h002081B3)
            $display("FAIL rtype_retire: instret=%0d ins=%08h expected 1 002081b3", instret, ins);
        else pass_cnt++;
    endtask

    task automatic test_alu_ops();
        logic [31:0] iw [3];
        logic [11:0] ex [3];
        logic [11:0] wb [3];
        iw = '{32'h402081B3, 32'h0020A1B3, 32'h00116193};
        ex = '{mk(0,0,0,0,0,0,2'b00,0,3'b110), mk(0,0,0,0,0,0,2'b00,0,3'b111),
               mk(0,0,0,0,0,0,2'b00,1,3'b001)};
        wb = '{mk(0,0,0,0,1,1,2'b00,0,3'b110), mk(0,0,0,0,1,1,2'b00,0,3'b111),
               mk(0,0,0,0,1,1,2'b00,1,3'b001)};
        for (int k = 0; k < 3; k++) begin
            logic [11:0] ev [4];
            ev = '{V_F, V_0, ex[k], wb[k]};
            memOut = iw[k];
            for (int i = 0; i < 4; i++) begin
                memReady = 1'b1;
                #1;
                total_cnt++;
                if (sig !== ev[i])
                    $display("FAIL alu_op%0d cyc%0d: got %03h expected %03h", k, i, sig, ev[i]);
                else pass_cnt++;
                @(negedge clk);
            end
        end
        #1;
        total_cnt++;
        if (instret !== 32'd4) $display("FAIL alu_instret: got %0d expected 4", instret);
        else pass_cnt++;
    endtask

    task automatic test_lw_stall();
        logic [11:0] ev [10];
        logic        rv [10];
        logic [11:0] vm;
        vm = mk(1,0,0,0,0,0,2'b00,1,3'b010);
        ev = '{V_F, V_F, V_F, V_0, mk(0,0,0,0,0,0,2'b00,1,3'b010),
               vm, vm, vm, vm, mk(0,0,1,0,1,1,2'b00,0,3'b000)};
        rv = '{0, 0, 1, 1, 1, 0, 0, 0, 1, 1};
        memOut = 32'h0000A183;
        for (int i = 0; i < 10; i++) begin
            memReady = rv[i];
            #1;
            total_cnt++;
            if (sig !== ev[i]) $display("FAIL lw_stall cyc%0d: got %03h expected %03h", i, sig, ev[i]);
            else pass_cnt++;
            @(negedge clk);
        end
        #1;
        total_cnt++;
        if (instret !== 32'd5 || ins !== 32'h0000A183)
            $display("FAIL lw_retire: instret=%0d ins=%08h expected 5 0000a183", instret, ins);
        else pass_cnt++;
    endtask

    task automatic test_sw();
        logic [11:0] ev [4];
        ev = '{V_F, V_0, mk(0,0,0,0,0,0,2'b00,1,3'b010), mk(0,1,0,0,0,1,2'b00,1,3'b010)};
        memOut = 32'h0030A023;
        for (int i = 0; i < 4; i++) begin
            memReady = 1'b1;
            #1;
            total_cnt++;
            if (sig !== ev[i]) $display("FAIL sw cyc%0d: got %03h expected %03h", i, sig, ev[i]);
            else pass_cnt++;
            @(negedge clk);
        end
        #1;
        total_cnt++;
        if (instret !== 32'd6) $display("FAIL sw_instret: got %0d expected 6", instret);
        else pass_cnt++;
    endtask

    task automatic test_beq();
        for (int z = 1; z >= 0; z--) begin
            logic [11:0] ev [3];
            ev = '{V_F, V_0, mk(0,0,0,0,0,1, (z == 1) ? 2'b01 : 2'b00, 0, 3'b110)};
            memOut = 32'h00208463;
            zero   = (z == 1);
            for (int i = 0; i < 3; i++) begin
                memReady = 1'b1;
                #1;
                total_cnt++;
                if (sig !== ev[i]) $display("FAIL beq_z%0d cyc%0d: got %03h expected %03h", z, i, sig, ev[i]);
                else pass_cnt++;
                @(negedge clk);
            end
        end
        zero = 1'b0;
        #1;
        total_cnt++;
        if (instret !== 32'd8) $display("FAIL beq_instret: got %0d expected 8", instret);
        else pass_cnt++;
    endtask

    task automatic test_jal();
        logic [11:0] ev [3];
        ev = '{V_F, V_0, mk(0,0,0,1,1,1,2'b10,0,3'b000)};
        memOut = 32'h008000EF;
        for (int i = 0; i < 3; i++) begin
            memReady = 1'b1;
            #1;
            total_cnt++;
            if (sig !== ev[i]) $display("FAIL jal cyc%0d: got %03h expected %03h", i, sig, ev[i]);
            else pass_cnt++;
            @(negedge clk);
        end
        #1;
        total_cnt++;
        if (instret !== 32'd9) $display("FAIL jal_instret: got %0d expected 9", instret);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_sw();
        logic [11:0] ev [4];
        logic        rv [4];
        ev = '{V_F, V_0, mk(0,0,0,0,0,0,2'b00,1,3'b010), mk(0,1,0,0,0,0,2'b00,1,3'b010)};
        rv = '{1, 0, 0, 0};
        memOut = 32'h0030A023;
        for (int i = 0; i < 4; i++) begin
            memReady = rv[i];
            #1;
            total_cnt++;
            if (sig !== ev[i]) $display("FAIL midsw cyc%0d: got %03h expected %03h", i, sig, ev[i]);
            else pass_cnt++;
            if (i < 3) @(negedge clk);
        end
        reset = 1'b1;
        #1;
        total_cnt++;
        if (sig !== V_0) $display("FAIL midsw_reset_strobes: got %03h expected %03h", sig, V_0);
        else pass_cnt++;
        @(negedge clk);
        reset = 1'b0;
        memReady = 1'b0;
        #1;
        total_cnt++;
        if (sig !== V_F || instret !== 32'd0 || ins !== 32'd0)
            $display("FAIL midsw_after: strobes=%03h instret=%0d ins=%08h expected %03h 0 0",
                     sig, instret, ins, V_F);
        else pass_cnt++;
    endtask

    task automatic test_wrap();
        force dut.instret_reg = 32'hFFFF_FFFF;
        #1;
        release dut.instret_reg;
        #1;
        total_cnt++;
        if (instret !== 32'hFFFF_FFFF) $display("FAIL wrap_preload: got %08h expected ffffffff", instret);
        else pass_cnt++;
        @(negedge clk);
        memOut = 32'h008000EF;
        for (int i = 0; i < 3; i++) begin
            memReady = 1'b1;
            @(negedge clk);
        end
        #1;
        total_cnt++;
        if (instret !== 32'd0) $display("FAIL wrap: got %08h expected 00000000", instret);
        else pass_cnt++;
    endtask

    task automatic test_illegal();
        memOut   = 32'h00000073;
        memReady = 1'b1;
        #1;
        total_cnt++;
        if (sig !== V_F) $display("FAIL ill_fetch: got %03h expected %03h", sig, V_F);
        else pass_cnt++;
        @(negedge clk); #1;
        total_cnt++;
        if (sig !== V_0 || illegal !== 1'b0)
            $display("FAIL ill_decode: strobes=%03h illegal=%b expected 000 0", sig, illegal);
        else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            total_cnt++;
            if (sig !== V_0 || illegal !== 1'b1)
                $display("FAIL ill_halt cyc%0d: strobes=%03h illegal=%b expected 000 1", i, sig, illegal);
            else pass_cnt++;
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        total_cnt++;
        if (illegal !== 1'b0 || sig !== V_F)
            $display("FAIL ill_clear: illegal=%b strobes=%03h expected 0 %03h", illegal, sig, V_F);
        else pass_cnt++;
    endtask

    initial begin
        reset    = 1'b1;
        memReady = 1'b0;
        memOut   = 32'd0;
        zero     = 1'b0;
        test_reset();
        test_rtype();
        test_alu_ops();
        test_lw_stall();
        test_sw();
        test_beq();
        test_jal();
        test_reset_mid_sw();
        test_wrap();
        test_illegal();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/ymc_control.md
# ymc_control

Multicycle control sequencer for the RV32I-subset datapath. It sits directly upstream of the execute, data-memory and write-back stages. Each cycle it drives their control inputs (`op`, `ALUSrc`, `MemRead`, `MemWrite`, `Mem2Reg`, `RegWrite`) and the PC-update strobes. It holds the current instruction in an internal instruction register and walks it through FETCH/DECODE/EXEC/MEM/WB. Memory accesses use a ready handshake, and the block counts retired instructions.

## Interface
Parameters:
- `IW`, default 32: instruction and counter width. Only 32 is supported.

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `memOut`  in  32  instruction word from memory; sampled in FETCH when `memReady`=1.
- `memReady`  in  1  memory completes the current access this cycle.
- `zero`  in  1  ALU zero flag from execute stage.
- `ins`  out  32  instruction register contents; feeds decode.
- `op`  out  3  ALU op: 000 and, 001 or, 010 add, 110 sub, 111 slt.
- `ALUSrc`  out  1  0 = rd2, 1 = immediate.
- `MemRead`  out  1  memory read request (instruction in FETCH, data in MEM).
- `MemWrite`  out  1  data memory write request.
- `Mem2Reg`  out  1  write-back selects memory data.
- `wbPC`  out  1  write-back selects PC+4 (JAL link).
- `RegWrite`  out  1  register file write enable.
- `pcWrite`  out  1  PC register load strobe.
- `pcSel`  out  2  next PC: 00 PC+4, 01 branch target, 10 jump target.
- `illegal`  out  1  sticky; unsupported instruction decoded.
- `instret`  out  32  count of retired instructions.

## Operation
- **States:** FETCH, DECODE, EXEC, MEM, WB, HALT, one-hot or binary (implementer's choice).
- **Reset:**
  - State goes to FETCH; `ins`=0, `instret`=0, `illegal`=0.
  - While `reset`=1, every output strobe is 0.
- **Output rule:** all unlisted strobes are 0 in every state. Outputs are combinational from state, `ins`, `zero` and `memReady`.
- **FETCH:**
  - `MemRead`=1.
  - If `memReady`: `ins` <= `memOut`, go to DECODE. Otherwise stay.
- **DECODE:** classify `ins[6:0]`.
  - 0110011 R-type, 0010011 I-ALU, 0000011 LW, 0100011 SW, 1100011 BEQ (funct3=000): go to EXEC.
  - 1101111 JAL: go to WB.
  - Anything else, or BEQ with funct3≠000: set `illegal`=1, go to HALT.
- **ALU op decode** (R-type and I-ALU):
  - funct3 000 → 010 (add), or 110 (sub) when R-type and `ins[30]`=1.
  - funct3 111 → 000; 110 → 001; 010 → 111.
  - Other funct3 values are illegal, detected in DECODE.
- **EXEC:**
  - R-type: `ALUSrc`=0, `op` per decode, go to WB.
  - I-ALU: `ALUSrc`=1, `op` per decode, go to WB.
  - LW/SW: `ALUSrc`=1, `op`=010, go to MEM.
  - BEQ:
    - Drive `ALUSrc`=0, `op`=110, `pcWrite`=1.
    - `pcSel`=01 if `zero`, else 00.
    - Increment `instret`, go to FETCH.
- **MEM:**
  - LW: hold `op`=010, `ALUSrc`=1, `MemRead`=1. On `memReady`, go to WB.
  - SW: hold `op`=010, `ALUSrc`=1, `MemWrite`=1. On `memReady`: `pcWrite`=1, `pcSel`=00, increment `instret`, go to FETCH.
  - With no `memReady`, stay in MEM and keep the strobes asserted.
- **WB:**
  - `RegWrite`=1, `pcWrite`=1.
  - `Mem2Reg`=1 for LW. For JAL, `wbPC`=1 and `pcSel`=10; otherwise `pcSel`=00.
  - For R-type and I-ALU, hold the EXEC values of `op` and `ALUSrc`.
  - Increment `instret`, go to FETCH.
- **HALT:** absorbing. All strobes 0; `illegal` stays 1 until reset.
- **`instret`:** increments exactly once per retirement and wraps 0xFFFFFFFF → 0.

## Timing
- Latency with `memReady` tied high:
  - BEQ and JAL: 3 cycles.
  - R-type, I-ALU, SW: 4 cycles.
  - LW: 5 cycles.
- Each cycle with `memReady`=0 in FETCH or MEM adds one cycle. Request strobes stay asserted throughout the wait.
- `ins` changes only on the FETCH handshake edge and is stable through DECODE to retirement.
- `pcWrite` is a single-cycle pulse per instruction, coincident with the `instret` increment edge.
- `reset` asserted in any state, including mid-wait in MEM: next state is FETCH with all registers cleared. No write strobe is asserted during the reset cycle.
- `memReady` outside FETCH/MEM is ignored.

## Test plan
- **Reset then R-type.** Stimulus: reset 2 cycles, `memReady`=1, `memOut`=0x002081B3 (add x3,x1,x2). Response: states F,D,E,W. WB cycle shows `RegWrite`=1, `op`=010, `pcWrite`=1, `pcSel`=00. `instret`=1 after 4 cycles.
- **Stalled LW.** Stimulus: `memOut`=0x0000A183 (lw x3,0(x1)); `memReady` low for 2 cycles in FETCH and 3 in MEM. Response: 10 total cycles. `MemRead` held throughout each stall; `Mem2Reg`=1 and `RegWrite`=1 only in WB.
- **BEQ, both outcomes.** Stimulus: `memOut`=0x00208463. Response: with `zero`=1, the EXEC cycle shows `pcSel`=01 and `pcWrite`=1; with `zero`=0, it shows `pcSel`=00. Both take 3 cycles, and `RegWrite` never asserts.
- **JAL.** Stimulus: `memOut`=0x008000EF. Response: F,D,W sequence; WB shows `wbPC`=1, `pcSel`=10, `RegWrite`=1.
- **Illegal opcode.** Stimulus: `memOut`=0x00000073. Response: `illegal`=1 from the cycle after DECODE, all strobes stay 0 indefinitely, and reset clears `illegal`.
- **Reset mid-SW and counter wrap.** Stimulus: assert reset in MEM with `MemWrite`=1. Response: `MemWrite` drops that cycle and FETCH follows. Separately, force `instret` to 0xFFFFFFFF via a long run or backdoor, then retire one instruction. Response: `instret` reads 0.
